// File: rtl/ccip_rd_engine.sv
// CCI-P read engine: streams num_lines cache lines from base_addr to a compute stage.
// Build option: define CCIP_RD_ENGINE_REORDER_EN for strict index-order delivery; default is arrival order.
module ccip_rd_engine #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CL_ADDR_W       = 42
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CL_ADDR_W-1:0] base_addr,
    input  logic [31:0]          num_lines,
    input  logic                 c0_alm_full,
    output logic                 c0_req_valid,
    output logic [CL_ADDR_W-1:0] c0_req_addr,
    output logic [15:0]          c0_req_mdata,
    input  logic                 c0_rsp_valid,
    input  logic [15:0]          c0_rsp_mdata,
    input  logic [511:0]         c0_rsp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [511:0]         out_data,
    output logic [31:0]          out_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int SLOT_W = $clog2(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [SLOT_W-1:0] ptr_t;
    typedef logic [SLOT_W:0]   cnt_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CL_ADDR_W-1:0] base_r;
    logic [31:0]          num_r;
    logic [31:0]          issued_r;
    logic [31:0]          delivered_r;
    logic [31:0]          issued_nxt_s;
    logic [31:0]          delivered_nxt_s;
    logic [7:0]           tag_r;

    logic                 c0_req_valid_r;
    logic [CL_ADDR_W-1:0] c0_req_addr_r;
    logic [15:0]          c0_req_mdata_r;
    logic                 out_valid_r;
    logic [511:0]         out_data_r;
    logic [31:0]          out_idx_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 accept_start_s;
    logic                 active_s;
    logic                 issue_s;
    logic                 rsp_ok_s;
    logic                 deliver_s;
    ptr_t                 rsp_slot_s;
    ptr_t                 issue_slot_s;
    logic                 out_vld_nxt_s;
    logic [511:0]         out_data_nxt_s;
    logic [31:0]          out_idx_nxt_s;

    assign accept_start_s = (state_r == IDLE) && start;
    assign active_s       = (state_r == RUN) || (state_r == DRAIN);
    assign issue_slot_s   = issued_r[SLOT_W-1:0];
    assign rsp_slot_s     = c0_rsp_mdata[SLOT_W-1:0];
    assign deliver_s      = out_valid_r && out_ready;

    // Credit uses the registered delivered count, so a slot freed this cycle is reusable next cycle.
    assign issue_s = (state_r == RUN) && !c0_alm_full && (issued_r < num_r) &&
                     ((issued_r - delivered_r) < 32'(MAX_OUTSTANDING));

    // Stale or malformed responses (old tag, out-of-range slot, engine idle) are dropped.
    assign rsp_ok_s = c0_rsp_valid && active_s && (c0_rsp_mdata[15:8] == tag_r) &&
                      ({1'b0, c0_rsp_mdata[7:0]} < 9'(MAX_OUTSTANDING));

    // Next-state logic for the job sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (num_lines == 32'd0) ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s && ((issued_r + 32'd1) == num_r)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (delivered_r == num_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Issue/delivery counters; cleared when a job is accepted
    always_comb begin
        issued_nxt_s    = issued_r;
        delivered_nxt_s = delivered_r;
        if (accept_start_s) begin
            issued_nxt_s    = 32'd0;
            delivered_nxt_s = 32'd0;
        end else begin
            issued_nxt_s    = issued_r + (issue_s ? 32'd1 : 32'd0);
            delivered_nxt_s = delivered_r + (deliver_s ? 32'd1 : 32'd0);
        end
    end

    // Job parameters and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r      <= {CL_ADDR_W{1'b0}};
            num_r       <= 32'd0;
            issued_r    <= 32'd0;
            delivered_r <= 32'd0;
        end else begin
            issued_r    <= issued_nxt_s;
            delivered_r <= delivered_nxt_s;
            if (accept_start_s) begin
                base_r <= base_addr;
                num_r  <= num_lines;
            end
        end
    end

    // Job tag survives reset so responses from an aborted job never match a later one
    always_ff @(posedge clk) begin
        if (!reset && accept_start_s) begin
            tag_r <= tag_r + 8'd1;
        end
    end

    // Registered read-request channel
    always_ff @(posedge clk) begin
        if (reset) begin
            c0_req_valid_r <= 1'b0;
            c0_req_addr_r  <= {CL_ADDR_W{1'b0}};
            c0_req_mdata_r <= 16'd0;
        end else begin
            c0_req_valid_r <= issue_s;
            if (issue_s) begin
                c0_req_addr_r  <= base_r + CL_ADDR_W'(issued_r);
                c0_req_mdata_r <= {tag_r, 8'(issue_slot_s)};
            end
        end
    end

`ifdef CCIP_RD_ENGINE_REORDER_EN
    logic [511:0]               slot_data_r [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] slot_vld_r;
    logic [MAX_OUTSTANDING-1:0] slot_vld_nxt_s;
    ptr_t                       head_s;
    ptr_t                       head_nxt_s;

    assign head_s     = delivered_r[SLOT_W-1:0];
    assign head_nxt_s = delivered_nxt_s[SLOT_W-1:0];

    // Slot occupancy: set on accepted response, cleared when the head is delivered
    always_comb begin
        slot_vld_nxt_s = slot_vld_r;
        if (accept_start_s) begin
            slot_vld_nxt_s = {MAX_OUTSTANDING{1'b0}};
        end else begin
            if (deliver_s) begin
                slot_vld_nxt_s[head_s] = 1'b0;
            end else begin
                slot_vld_nxt_s[head_s] = slot_vld_r[head_s];
            end
            if (rsp_ok_s) begin
                slot_vld_nxt_s[rsp_slot_s] = 1'b1;
            end else begin
                slot_vld_nxt_s[rsp_slot_s] = slot_vld_nxt_s[rsp_slot_s];
            end
        end
    end

    // Slot valid register
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld_r <= {MAX_OUTSTANDING{1'b0}};
        end else begin
            slot_vld_r <= slot_vld_nxt_s;
        end
    end

    // Slot data storage
    always_ff @(posedge clk) begin
        if (rsp_ok_s) begin
            slot_data_r[rsp_slot_s] <= c0_rsp_data;
        end
    end

    // Present the next head slot; a response landing in it this cycle is forwarded directly
    always_comb begin
        out_vld_nxt_s = slot_vld_nxt_s[head_nxt_s];
        out_idx_nxt_s = delivered_nxt_s;
        if (rsp_ok_s && (rsp_slot_s == head_nxt_s)) begin
            out_data_nxt_s = c0_rsp_data;
        end else begin
            out_data_nxt_s = slot_data_r[head_nxt_s];
        end
    end
`else
    logic [511:0] fifo_data_r [MAX_OUTSTANDING];
    logic [31:0]  fifo_idx_r  [MAX_OUTSTANDING];
    logic [31:0]  idx_tab_r   [MAX_OUTSTANDING];
    ptr_t         wr_ptr_r;
    ptr_t         rd_ptr_r;
    ptr_t         rd_ptr_nxt_s;
    cnt_t         count_r;
    cnt_t         count_nxt_s;
    logic         bypass_s;

    // Arrival-order FIFO bookkeeping; bypass when the pushed entry becomes the head at once
    always_comb begin
        if (accept_start_s) begin
            rd_ptr_nxt_s = {SLOT_W{1'b0}};
            count_nxt_s  = {(SLOT_W+1){1'b0}};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r + ptr_t'(deliver_s);
            count_nxt_s  = count_r + cnt_t'(rsp_ok_s) - cnt_t'(deliver_s);
        end
        bypass_s      = rsp_ok_s && (count_r == cnt_t'(deliver_s));
        out_vld_nxt_s = (count_nxt_s != {(SLOT_W+1){1'b0}});
        if (bypass_s) begin
            out_data_nxt_s = c0_rsp_data;
            out_idx_nxt_s  = idx_tab_r[rsp_slot_s];
        end else begin
            out_data_nxt_s = fifo_data_r[rd_ptr_nxt_s];
            out_idx_nxt_s  = fifo_idx_r[rd_ptr_nxt_s];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {SLOT_W{1'b0}};
            rd_ptr_r <= {SLOT_W{1'b0}};
            count_r  <= {(SLOT_W+1){1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            if (accept_start_s) begin
                wr_ptr_r <= {SLOT_W{1'b0}};
            end else if (rsp_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_t'(1'b1);
            end
        end
    end

    // FIFO storage and slot-to-line-index table
    always_ff @(posedge clk) begin
        if (rsp_ok_s) begin
            fifo_data_r[wr_ptr_r] <= c0_rsp_data;
            fifo_idx_r[wr_ptr_r]  <= idx_tab_r[rsp_slot_s];
        end
        if (issue_s) begin
            idx_tab_r[issue_slot_s] <= issued_r;
        end
    end
`endif

    // Registered output stream; data only reloads while a line is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 512'd0;
            out_idx_r   <= 32'd0;
        end else begin
            out_valid_r <= out_vld_nxt_s;
            if (out_vld_nxt_s) begin
                out_data_r <= out_data_nxt_s;
                out_idx_r  <= out_idx_nxt_s;
            end
        end
    end

    // Status flags track the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
            done_r <= (state_nxt_s == DONE);
        end
    end

    assign c0_req_valid = c0_req_valid_r;
    assign c0_req_addr  = c0_req_addr_r;
    assign c0_req_mdata = c0_req_mdata_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_idx      = out_idx_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_ccip_rd_engine.sv
// Self-checking bench for ccip_rd_engine: job table plus hand sequences, scoreboard of delivered lines.
module tb_ccip_rd_engine;
    localparam int MAXO = 16;
    localparam int AW   = 42;
`ifdef CCIP_RD_ENGINE_REORDER_EN
    localparam bit REORDER = 1'b1;
`else
    localparam bit REORDER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, c0_alm_full;
    logic [AW-1:0] base_addr;
    logic [31:0]   num_lines;
    logic          c0_req_valid;
    logic [AW-1:0] c0_req_addr;
    logic [15:0]   c0_req_mdata;
    logic          c0_rsp_valid;
    logic [15:0]   c0_rsp_mdata;
    logic [511:0]  c0_rsp_data;
    logic          out_valid, out_ready;
    logic [511:0]  out_data;
    logic [31:0]   out_idx;
    logic          busy, done;

    always #5 clk = ~clk;

    ccip_rd_engine #(.MAX_OUTSTANDING(MAXO), .CL_ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
        .c0_alm_full(c0_alm_full), .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
        .c0_req_mdata(c0_req_mdata), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata),
        .c0_rsp_data(c0_rsp_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    typedef struct { logic [31:0] idx; logic [511:0] data; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [15:0] mdata; } pend_t;
    typedef struct {
        logic [AW-1:0] base; int nlines; int rsp_mode; int rdy_mode; int alm_off; int alm_len;
        int exp_reqs; int exp_done;
    } job_t;

    exp_t  sb[$];
    pend_t pend[$];
    pend_t stale[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_req, n_del, n_done;
    int rsp_mode = 0;
    int rdy_mode = 0;
    int alm_lo = 0;
    int alm_hi = 0;
    bit responder_on = 1'b0;
    bit tag_known = 1'b0;
    logic [7:0] exp_tag = 8'd0;
    logic [AW-1:0] job_base;
    bit prev_stall = 1'b0;
    logic [511:0] prev_data;
    bit inj_valid = 1'b0;
    bit inj_push = 1'b0;
    logic [AW-1:0] inj_addr;
    logic [15:0] inj_mdata;

    function automatic logic [511:0] data_of(input logic [AW-1:0] a);
        logic [63:0] w;
        w = {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
        return {8{w}};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a);
        exp_t e;
        logic [AW-1:0] d;
        d = a - job_base;
        e.idx = d[31:0];
        e.data = data_of(a);
        sb.push_back(e);
    endtask

    // One cycle: observe at negedge, then drive inputs for the next posedge.
    task automatic tick();
        int k;
        exp_t e;
        pend_t p;
        logic [AW-1:0] ea;
        @(negedge clk);
        cyc++;
        if (prev_stall && !reset) begin
            check("stall_valid_hold", 512'(out_valid), 512'd1);
            check("stall_data_hold", out_data, prev_data);
        end
        if (c0_req_valid) begin
            ea = job_base + AW'(n_req);
            check("req_addr", 512'(c0_req_addr), 512'(ea));
            check("req_slot", 512'(c0_req_mdata[7:0]), 512'(n_req % MAXO));
            check("req_when_alm_full", 512'(c0_alm_full), 512'd0);
            if (!tag_known) begin
                exp_tag = c0_req_mdata[15:8];
                tag_known = 1'b1;
            end else begin
                check("req_tag", 512'(c0_req_mdata[15:8]), 512'(exp_tag));
            end
            if (REORDER) push_exp(c0_req_addr);
            p.addr = c0_req_addr;
            p.mdata = c0_req_mdata;
            pend.push_back(p);
            n_req++;
            check("credit_limit", 512'(n_req - n_del > MAXO), 512'd0);
        end
        if (done) n_done++;
        c0_alm_full = (cyc >= alm_lo) && (cyc < alm_hi);
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
        c0_rsp_valid = 1'b0;
        if (inj_valid) begin
            c0_rsp_valid = 1'b1;
            c0_rsp_mdata = inj_mdata;
            c0_rsp_data = data_of(inj_addr);
            if (!REORDER && inj_push) push_exp(inj_addr);
            inj_valid = 1'b0;
        end else if (responder_on && pend.size() > 0 && (rsp_mode == 0 || $urandom_range(0, 3) != 0)) begin
            k = (rsp_mode == 0) ? 0 : int'($urandom_range(0, pend.size() - 1));
            p = pend[k];
            pend.delete(k);
            c0_rsp_valid = 1'b1;
            c0_rsp_mdata = p.mdata;
            c0_rsp_data = data_of(p.addr);
            if (!REORDER) push_exp(p.addr);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_delivery: idx=%0d with empty scoreboard", out_idx);
            end else begin
                e = sb.pop_front();
                check("out_idx", 512'(out_idx), 512'(e.idx));
                check("out_data", out_data, e.data);
            end
            n_del++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
    endtask

    task automatic start_job(input logic [AW-1:0] b, input int n);
        job_base = b;
        n_req = 0;
        n_del = 0;
        n_done = 0;
        if (tag_known) exp_tag = exp_tag + 8'd1;
        base_addr = b;
        num_lines = 32'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 512'(busy), 512'(n > 0));
        check("done_after_start", 512'(done), 512'(n == 0));
    endtask

    task automatic wait_done(input int budget, input int exp_n);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        if (n_done == 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done after %0d cycles, delivered=%0d", budget, n_del);
        end
        repeat (3) tick();
        check("done_pulses", 512'(n_done), 512'd1);
        check("req_count", 512'(n_req), 512'(exp_n));
        check("deliver_count", 512'(n_del), 512'(exp_n));
        check("scoreboard_empty", 512'(sb.size()), 512'd0);
        check("busy_idle", 512'(busy), 512'd0);
    endtask

    task automatic wait_reqs(input int n);
        int k;
        k = 0;
        while (n_req < n && k < 100) begin
            tick();
            k++;
        end
        check("reqs_reached", 512'(n_req), 512'(n));
    endtask

    task automatic inject(input logic [AW-1:0] a, input logic [15:0] md, input bit push);
        inj_valid = 1'b1;
        inj_addr = a;
        inj_mdata = md;
        inj_push = push;
        tick();
    endtask

    task automatic inject_line(input logic [AW-1:0] a);
        int f;
        f = -1;
        foreach (pend[i]) if (pend[i].addr == a && f < 0) f = i;
        if (f < 0) begin
            total++;
            bad++;
            $display("FAIL inject_line: no pending request for %0h", a);
        end else begin
            inject(a, pend[f].mdata, 1'b1);
            pend.delete(f);
        end
    endtask

    task automatic do_reset(input bit with_start);
        responder_on = 1'b0;
        reset = 1'b1;
        start = with_start;
        num_lines = 32'd7;
        tick();
        start = 1'b0;
        tick();
        check("rst_req_valid", 512'(c0_req_valid), 512'd0);
        check("rst_out_valid", 512'(out_valid), 512'd0);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_done", 512'(done), 512'd0);
        check("rst_req_addr", 512'(c0_req_addr), 512'd0);
        check("rst_req_mdata", 512'(c0_req_mdata), 512'd0);
        check("rst_out_data", out_data, 512'd0);
        check("rst_out_idx", 512'(out_idx), 512'd0);
        reset = 1'b0;
        tick();
        check("post_rst_busy", 512'(busy), 512'd0);
        sb.delete();
        pend.delete();
        prev_stall = 1'b0;
    endtask

    job_t jobs[6];

    initial begin
        jobs[0] = '{42'h1000,        4,  0, 0, 0,  0,  4,  1};
        jobs[1] = '{42'h2000,        25, 1, 1, 0,  0,  25, 1};
        jobs[2] = '{42'h3000_0000,   30, 0, 0, 6,  10, 30, 1};
        jobs[3] = '{42'h3FF_FFFF_FFFE, 5, 1, 1, 0, 0,  5,  1};
        jobs[4] = '{42'h4000,        0,  0, 0, 0,  0,  0,  1};
        jobs[5] = '{42'h5555,        50, 1, 1, 20, 10, 50, 1};

        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_lines = 32'd0;
        c0_alm_full = 1'b0;
        c0_rsp_valid = 1'b0;
        c0_rsp_mdata = 16'd0;
        c0_rsp_data = 512'd0;
        out_ready = 1'b0;
        job_base = '0;
        n_req = 0;
        n_del = 0;
        n_done = 0;
        do_reset(1'b0);

        for (int j = 0; j < 6; j++) begin
            rsp_mode = jobs[j].rsp_mode;
            rdy_mode = jobs[j].rdy_mode;
            responder_on = 1'b1;
            start_job(jobs[j].base, jobs[j].nlines);
            if (jobs[j].alm_len > 0) begin
                alm_lo = cyc + jobs[j].alm_off;
                alm_hi = alm_lo + jobs[j].alm_len;
            end
            wait_done(3000, jobs[j].exp_reqs);
            check("job_done_count", 512'(n_done), 512'(jobs[j].exp_done));
            alm_lo = 0;
            alm_hi = 0;
        end

        // Out-of-order responses 3,1,0,2
        responder_on = 1'b0;
        rdy_mode = 0;
        start_job(42'h7000, 4);
        wait_reqs(4);
        inject_line(42'h7003);
        inject_line(42'h7001);
        inject_line(42'h7000);
        inject_line(42'h7002);
        wait_done(200, 4);

        // Credit exhaustion with the consumer stalled, plus a start that must be ignored
        responder_on = 1'b1;
        rsp_mode = 0;
        rdy_mode = 2;
        start_job(42'h9000, 40);
        repeat (60) tick();
        check("stall_req_count", 512'(n_req), 512'(MAXO));
        check("stall_out_valid", 512'(out_valid), 512'd1);
        base_addr = 42'hDEAD;
        num_lines = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_ignores_start", 512'(busy), 512'd1);
        rdy_mode = 0;
        wait_done(1000, 40);

        // Mid-job reset, then stale responses while a short job runs
        responder_on = 1'b0;
        rdy_mode = 0;
        start_job(42'hA000, 20);
        wait_reqs(5);
        stale = pend;
        do_reset(1'b1);
        check("reqs_frozen_by_reset", 512'(n_req), 512'd5);
        start_job(42'hB000, 2);
        wait_reqs(2);
        inject(stale[0].addr, stale[0].mdata, 1'b0);
        inject(stale[1].addr, stale[1].mdata, 1'b0);
        inject_line(42'hB001);
        inject(stale[2].addr, stale[2].mdata, 1'b0);
        inject_line(42'hB000);
        inject(stale[3].addr, stale[3].mdata, 1'b0);
        inject(stale[4].addr, stale[4].mdata, 1'b0);
        wait_done(200, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccip_rd_engine.md
CCIP_RD_ENGINE -- requirements
Module: ccip_rd_engine

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16, giving max in-flight reads and the buffer depth; power of 2, range 2..256.
REQ-002 SHALL have parameter CL_ADDR_W, default 42, giving the cache-line address width.
REQ-003 clk  in  1  clock; all logic SHALL be synchronous to posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle job start pulse.
REQ-006 base_addr  in  CL_ADDR_W  first source cache-line address.
REQ-007 num_lines  in  32  number of lines to read.
REQ-008 c0_alm_full  in  1  read-request channel almost full.
REQ-009 c0_req_valid / c0_req_addr / c0_req_mdata  out  1/CL_ADDR_W/16  read request.
REQ-010 c0_rsp_valid / c0_rsp_mdata / c0_rsp_data  in  1/16/512  read response; responses may return in any order.
REQ-011 out_valid / out_ready / out_data / out_idx  out/in/out/out  1/1/512/32  line stream to the compute stage; out_idx is the line index within the job.
REQ-012 busy / done  out  1/1  job active / one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-014 State transitions SHALL be as follows:
- IDLE to RUN: on start with num_lines>0; base_addr and num_lines are latched.
- IDLE to DONE: on start with num_lines==0.
- RUN to DRAIN: after the last request issues.
- DRAIN to DONE: when delivered==num_lines.
- DONE to IDLE: after exactly one cycle.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 only in DONE.
REQ-017 A request SHALL issue in a cycle only when all of the following hold: state RUN, !c0_alm_full, issued<num_lines, and (issued-delivered)<MAX_OUTSTANDING.
- At most one request issues per cycle.
- Outputs are registered.
REQ-018 c0_req_addr SHALL equal latched base plus issued, modulo 2^CL_ADDR_W (wraps silently).
REQ-019 c0_req_mdata[7:0] SHALL carry the buffer slot, equal to issued mod MAX_OUTSTANDING.
REQ-020 c0_req_mdata[15:8] SHALL carry the 8-bit job tag.
REQ-021 The job tag SHALL increment on every accepted start.
REQ-022 A response SHALL be written to the buffer at slot mdata[7:0] only when mdata[15:8] equals the current tag and state is RUN or DRAIN; otherwise it SHALL be discarded.
REQ-023 out_valid SHALL assert when the head slot (delivered mod MAX_OUTSTANDING) holds data.
- Minimum latency is 1 cycle from c0_rsp_valid to out_valid.
REQ-024 Delivery SHALL occur when out_valid && out_ready.
- On delivery, the head slot is freed and delivered increments.
- out_data and out_valid SHALL remain stable while out_ready is low.
REQ-025 out_idx SHALL equal the line index of the presented data.
REQ-026 A response write and a delivery SHALL both take effect when they occur in the same cycle.
REQ-027 A request issued in the same cycle a slot frees SHALL use the credit as it stood before the free; the freed credit is usable the next cycle.
REQ-028 issued and delivered SHALL be 32-bit counters that never exceed num_lines.

Reset
REQ-029 On reset, the following SHALL take these values:
- state=IDLE.
- c0_req_valid=0, out_valid=0, busy=0, done=0.
- issued=0, delivered=0, all slot-valid bits=0.
- c0_req_addr=0, c0_req_mdata=0, out_data=0, out_idx=0.
REQ-030 The job tag SHALL be the only register excluded from reset.
- Responses in flight across a mid-job reset are therefore rejected by the tag check in later jobs.
REQ-031 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-032 Macro CCIP_RD_ENGINE_REORDER_EN SHALL control in-order delivery.
- Defined: lines are delivered strictly in index order through the slot buffer.
- Undefined: lines are delivered in arrival order through a MAX_OUTSTANDING-deep FIFO.
- Undefined: out_idx is taken from a per-slot line-index table.
- Undefined: credits are freed on FIFO pop.

Verification
REQ-033 base=0x1000, num_lines=4, responses in order, out_ready=1 -> requests issue to 0x1000..0x1003; out_idx 0..3 delivered; done pulses once.
REQ-034 REORDER_EN defined, num_lines=4, responses return in order 3,1,0,2 -> out_idx strictly 0,1,2,3 with matching data.
REQ-035 MAX_OUTSTANDING=16, num_lines=40, out_ready=0 -> exactly 16 requests issue, then c0_req_valid stays 0; after out_ready=1, all 40 delivered.
REQ-036 c0_alm_full=1 for 10 cycles mid-job -> no requests during those cycles; job completes with no lost or duplicated lines.
REQ-037 num_lines=0 -> no requests; done pulses 1 cycle after start; busy stays 0.
REQ-038 Reset after 5 of 20 requests, then a new job with num_lines=2 while stale responses arrive -> stale responses are discarded; exactly 2 correct lines are delivered.
